// File: rtl/word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : word_unpacker
// Purpose  : Pops packed wide words and replays their elements one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module word_unpacker #(
    parameter int ELEM_WIDTH = 16,
    parameter int NB_ELEMS   = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic [ELEM_WIDTH*NB_ELEMS-1:0]   din,
    input  logic [$clog2(NB_ELEMS+1)-1:0]    din_len,
    input  logic                             input_valid,
    output logic                             input_ready,
    output logic [ELEM_WIDTH-1:0]            qout,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic                             last_elem,
    output logic                             busy
);

    localparam int c_len_w = $clog2(NB_ELEMS+1);
    localparam int c_idx_w = $clog2(NB_ELEMS);
    localparam logic [c_len_w-1:0] c_nb_len  = c_len_w'(NB_ELEMS);
    localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [c_idx_w-1:0]             r_idx;
    logic [c_idx_w-1:0]             w_idx_nxt;
    logic [ELEM_WIDTH*NB_ELEMS-1:0] r_hold_word;
    logic [c_len_w-1:0]             r_hold_len;
    logic [c_len_w-1:0]             w_len_eff;
    logic                           w_load;
    logic                           w_in_fire;
    logic                           w_out_fire;
    logic                           w_last;
    logic [ELEM_WIDTH-1:0]          w_elems [NB_ELEMS];

    // Length 0 means a full word; oversize lengths are clamped.
    always_comb begin
        w_len_eff = din_len;
        if (din_len == '0 || din_len > c_nb_len) begin
            w_len_eff = c_nb_len;
        end
    end

    for (genvar gi = 0; gi < NB_ELEMS; gi++) begin : g_elem
        if (LSB_FIRST != 0) begin : g_lsb
            assign w_elems[gi] = r_hold_word[gi*ELEM_WIDTH +: ELEM_WIDTH];
        end else begin : g_msb
            assign w_elems[gi] = r_hold_word[(NB_ELEMS-1-gi)*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end

    assign output_valid = (r_state == ST_DRAIN);
    assign busy         = output_valid;
    assign qout         = w_elems[r_idx];
    assign w_last       = output_valid && (c_len_w'(r_idx) == (r_hold_len - c_len_one));
    assign last_elem    = w_last;
    assign w_out_fire   = output_valid && output_ready;
    // Ready may come from downstream ready on the last element, never from input_valid.
    assign input_ready  = (r_state == ST_EMPTY) || (w_out_fire && w_last);
    assign w_in_fire    = input_valid && input_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_fire) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + c_idx_one;
                    end else begin
                        w_idx_nxt = '0;
                        if (w_in_fire) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state     <= ST_EMPTY;
            r_idx       <= '0;
            r_hold_word <= '0;
            r_hold_len  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_load) begin
                r_hold_word <= din;
                r_hold_len  <= w_len_eff;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_x_ctrl : assert property (@(posedge clk) disable iff (!arst_n_in)
        !$isunknown({output_valid, input_ready}));

    a_stable_bp : assert property (@(posedge clk) disable iff (!arst_n_in)
        (output_valid && !output_ready) |=>
            (output_valid && $stable(qout) && $stable(last_elem)));

    a_ready_ok : assert property (@(posedge clk) disable iff (!arst_n_in)
        input_ready |-> (r_state == ST_EMPTY || last_elem));

    a_len_range : assert property (@(posedge clk) disable iff (!arst_n_in)
        input_valid |-> (din_len <= c_nb_len));
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_unpacker
// Purpose  : Directed self-checking bench for word_unpacker (both element orders).
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_unpacker;

    localparam int c_ew = 16;
    localparam int c_ne = 4;

    logic        clk;
    logic        arst_n;

    logic [63:0] din_a;
    logic [2:0]  len_a;
    logic        iv_a, ir_a, ov_a, or_a, last_a, busy_a;
    logic [15:0] qout_a;

    logic [63:0] din_b;
    logic [2:0]  len_b;
    logic        iv_b, ir_b, ov_b, or_b, last_b, busy_b;
    logic [15:0] qout_b;

    int n_checks;
    int n_fail;

    word_unpacker #(.ELEM_WIDTH(c_ew), .NB_ELEMS(c_ne), .LSB_FIRST(1)) u_dut_lsb (
        .clk          (clk),
        .arst_n_in    (arst_n),
        .din          (din_a),
        .din_len      (len_a),
        .input_valid  (iv_a),
        .input_ready  (ir_a),
        .qout         (qout_a),
        .output_valid (ov_a),
        .output_ready (or_a),
        .last_elem    (last_a),
        .busy         (busy_a)
    );

    word_unpacker #(.ELEM_WIDTH(c_ew), .NB_ELEMS(c_ne), .LSB_FIRST(0)) u_dut_msb (
        .clk          (clk),
        .arst_n_in    (arst_n),
        .din          (din_b),
        .din_len      (len_b),
        .input_valid  (iv_b),
        .input_ready  (ir_b),
        .qout         (qout_b),
        .output_valid (ov_b),
        .output_ready (or_b),
        .last_elem    (last_b),
        .busy         (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] w1;
        logic [63:0] w2;
        logic        pat [7];
        int          e;
        int          nfire;

        w1 = 64'h0004_0003_0002_0001;
        w2 = 64'h0008_0007_0006_0005;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        n_checks = 0;
        n_fail   = 0;

        arst_n = 1'b0;
        din_a = '0; len_a = '0; iv_a = 1'b0; or_a = 1'b0;
        din_b = '0; len_b = '0; iv_b = 1'b0; or_b = 1'b0;
        #3;
        check("rst_ov",   {63'd0, ov_a},   64'd0);
        check("rst_ir",   {63'd0, ir_a},   64'd1);
        check("rst_qout", {48'd0, qout_a}, 64'd0);
        check("rst_last", {63'd0, last_a}, 64'd0);
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        #9;
        arst_n = 1'b1;
        cyc();

        // Single full word, len 0 means all four elements.
        din_a = w1; len_a = 3'd0; iv_a = 1'b1; or_a = 1'b1;
        #1;
        check("w1_ir_empty", {63'd0, ir_a}, 64'd1);
        cyc();
        iv_a = 1'b0; din_a = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("w1_ov",   {63'd0, ov_a},   64'd1);
            check("w1_qout", {48'd0, qout_a}, 64'(k + 1));
            check("w1_last", {63'd0, last_a}, 64'(k == 3));
            check("w1_ir",   {63'd0, ir_a},   64'(k == 3));
            cyc();
        end
        #1;
        check("w1_done_ov", {63'd0, ov_a}, 64'd0);
        check("w1_done_ir", {63'd0, ir_a}, 64'd1);

        // Two words back to back with no bubble.
        din_a = w1; len_a = 3'd0; iv_a = 1'b1;
        #1;
        cyc();
        din_a = w2;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) iv_a = 1'b0;
            #1;
            check("b2b_ov",   {63'd0, ov_a},   64'd1);
            check("b2b_qout", {48'd0, qout_a}, 64'(k + 1));
            check("b2b_last", {63'd0, last_a}, 64'(k == 3 || k == 7));
            check("b2b_ir",   {63'd0, ir_a},   64'(k == 3 || k == 7));
            cyc();
        end
        #1;
        check("b2b_done_ov", {63'd0, ov_a}, 64'd0);

        // Partial word of two elements.
        din_a = 64'h00AA_00BB_00CC_00DD; len_a = 3'd2; iv_a = 1'b1;
        #1;
        cyc();
        iv_a = 1'b0; len_a = 3'd0;
        #1;
        check("part_q0",    {48'd0, qout_a}, 64'h00DD);
        check("part_last0", {63'd0, last_a}, 64'd0);
        check("part_ir0",   {63'd0, ir_a},   64'd0);
        cyc();
        #1;
        check("part_q1",    {48'd0, qout_a}, 64'h00CC);
        check("part_last1", {63'd0, last_a}, 64'd1);
        check("part_ir1",   {63'd0, ir_a},   64'd1);
        cyc();
        #1;
        check("part_done_ov", {63'd0, ov_a}, 64'd0);
        cyc();
        #1;
        check("part_idle_ov", {63'd0, ov_a}, 64'd0);

        // Single-element word.
        din_a = 64'h0000_0000_0000_0055; len_a = 3'd1; iv_a = 1'b1;
        #1;
        cyc();
        iv_a = 1'b0; len_a = 3'd0;
        #1;
        check("len1_qout", {48'd0, qout_a}, 64'h0055);
        check("len1_last", {63'd0, last_a}, 64'd1);
        check("len1_ir",   {63'd0, ir_a},   64'd1);
        cyc();
        #1;
        check("len1_done_ov", {63'd0, ov_a}, 64'd0);

        // Backpressure pattern 1,0,0,1,1,0,1 across one four-element word.
        din_a = w1; len_a = 3'd0; iv_a = 1'b1; or_a = 1'b1;
        #1;
        cyc();
        iv_a = 1'b0;
        e = 0;
        nfire = 0;
        for (int i = 0; i < 7; i++) begin
            or_a = pat[i];
            #1;
            check("bp_ov",   {63'd0, ov_a},   64'd1);
            check("bp_qout", {48'd0, qout_a}, 64'(e + 1));
            check("bp_last", {63'd0, last_a}, 64'(e == 3));
            check("bp_ir",   {63'd0, ir_a},   64'(e == 3 && pat[i]));
            if (ov_a && or_a) nfire++;
            if (pat[i]) e++;
            cyc();
        end
        or_a = 1'b1;
        #1;
        check("bp_nfire",   64'(nfire),      64'd4);
        check("bp_done_ov", {63'd0, ov_a},   64'd0);

        // MSB-first instance.
        din_b = 64'h0001_0002_0003_0004; len_b = 3'd0; iv_b = 1'b1; or_b = 1'b1;
        #1;
        check("msb_ir_empty", {63'd0, ir_b}, 64'd1);
        cyc();
        iv_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("msb_ov",   {63'd0, ov_b},   64'd1);
            check("msb_qout", {48'd0, qout_b}, 64'(k + 1));
            check("msb_last", {63'd0, last_b}, 64'(k == 3));
            cyc();
        end
        #1;
        check("msb_done_ov", {63'd0, ov_b}, 64'd0);

        // Asynchronous reset in the middle of a word.
        din_a = w1; len_a = 3'd0; iv_a = 1'b1; or_a = 1'b1;
        #1;
        cyc();
        iv_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("ar_pre_qout", {48'd0, qout_a}, 64'(k + 1));
            cyc();
        end
        #1;
        arst_n = 1'b0;
        #1;
        check("ar_ov",   {63'd0, ov_a},   64'd0);
        check("ar_qout", {48'd0, qout_a}, 64'd0);
        check("ar_last", {63'd0, last_a}, 64'd0);
        check("ar_busy", {63'd0, busy_a}, 64'd0);
        check("ar_ir",   {63'd0, ir_a},   64'd1);
        #3;
        arst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            check("ar_post_ov", {63'd0, ov_a}, 64'd0);
            check("ar_post_ir", {63'd0, ir_a}, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
